// File: rtl/cache_controller.sv
// Sequencing controller for a 2-way set-associative, write-back, write-allocate
// L1 cache with one-byte blocks; serves one CPU port and one memory port.
module cache_controller #(
  parameter int SETS   = 4,
  parameter int TAG_W  = 8,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hit,
  output logic              busy,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [7:0]        hit_cnt,
  output logic [7:0]        miss_cnt
);
  localparam int IDX_W = $clog2(SETS);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WRITEBACK, S_FILL, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic                    we_q, we_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [1:0][SETS-1:0]    valid_q, valid_d;
  logic [1:0][SETS-1:0]    dirty_q, dirty_d;
  logic [SETS-1:0]         lru_q, lru_d;
  logic                    victim_q, victim_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    hit_q, hit_d;
  logic [7:0]              hit_cnt_q, hit_cnt_d;
  logic [7:0]              miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0]        tag_q  [2][SETS];
  logic [DATA_W-1:0]       data_q [2][SETS];

  logic                    arr_we;
  logic                    arr_way;
  logic [DATA_W-1:0]       arr_data;

  logic [IDX_W-1:0]        idx;
  logic [TAG_W-1:0]        tag;
  logic [1:0]              way_hit;
  logic                    hit_way;
  logic                    victim_sel;

  assign idx = addr_q[IDX_W-1:0];
  assign tag = addr_q[ADDR_W-1:IDX_W];

  for (genvar gi = 0; gi < 2; gi++) begin : g_way_cmp
    assign way_hit[gi] = valid_q[gi][idx] && (tag_q[gi][idx] == tag);
  end

  assign hit_way    = way_hit[1];
  // Fill an empty way first; only evict by LRU when the set is full.
  assign victim_sel = !valid_q[0][idx] ? 1'b0 :
                      !valid_q[1][idx] ? 1'b1 : lru_q[idx];

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    lru_d      = lru_q;
    victim_d   = victim_q;
    rdata_d    = rdata_q;
    hit_d      = hit_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    arr_we     = 1'b0;
    arr_way    = victim_q;
    arr_data   = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (|way_hit) begin
          hit_d      = 1'b1;
          hit_cnt_d  = hit_cnt_q + 8'd1;
          lru_d[idx] = ~hit_way;
          if (we_q) begin
            arr_we                = 1'b1;
            arr_way               = hit_way;
            dirty_d[hit_way][idx] = 1'b1;
            rdata_d               = wdata_q;
          end else begin
            rdata_d = data_q[hit_way][idx];
          end
          state_d = S_DONE;
        end else begin
          hit_d      = 1'b0;
          miss_cnt_d = miss_cnt_q + 8'd1;
          victim_d   = victim_sel;
          if (valid_q[victim_sel][idx] && dirty_q[victim_sel][idx]) begin
            state_d = S_WRITEBACK;
          end else if (!we_q) begin
            state_d = S_FILL;
          end else begin
            arr_we                   = 1'b1;
            arr_way                  = victim_sel;
            valid_d[victim_sel][idx] = 1'b1;
            dirty_d[victim_sel][idx] = 1'b1;
            lru_d[idx]               = ~victim_sel;
            rdata_d                  = wdata_q;
            state_d                  = S_DONE;
          end
        end
      end
      S_WRITEBACK: begin
        if (mem_ack) begin
          if (we_q) begin
            arr_we                 = 1'b1;
            valid_d[victim_q][idx] = 1'b1;
            dirty_d[victim_q][idx] = 1'b1;
            lru_d[idx]             = ~victim_q;
            rdata_d                = wdata_q;
            state_d                = S_DONE;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (mem_ack) begin
          arr_we                 = 1'b1;
          arr_data               = mem_rdata;
          valid_d[victim_q][idx] = 1'b1;
          dirty_d[victim_q][idx] = 1'b0;
          lru_d[idx]             = ~victim_q;
          rdata_d                = mem_rdata;
          state_d                = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      lru_q      <= '0;
      victim_q   <= 1'b0;
      rdata_q    <= '0;
      hit_q      <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      lru_q      <= lru_d;
      victim_q   <= victim_d;
      rdata_q    <= rdata_d;
      hit_q      <= hit_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Tag and data contents need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clock) begin
    if (arr_we) begin
      tag_q[arr_way][idx]  <= tag;
      data_q[arr_way][idx] <= arr_data;
    end
  end

  always_comb begin
    cpu_done  = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    mem_wr    = (state_q == S_WRITEBACK);
    mem_rd    = (state_q == S_FILL);
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == S_WRITEBACK) begin
      mem_addr  = {tag_q[victim_q][idx], idx};
      mem_wdata = data_q[victim_q][idx];
    end else if (state_q == S_FILL) begin
      mem_addr = addr_q;
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_hit   = hit_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;
endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: directed scenarios plus random traffic
// checked against a behavioural cache/memory model.
module tb_cache_controller;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cpu_req, cpu_we;
  logic [9:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_done, cpu_hit, busy, mem_rd, mem_wr, mem_ack;
  logic [7:0] cpu_rdata, mem_wdata, mem_rdata, hit_cnt, miss_cnt;
  logic [9:0] mem_addr;

  cache_controller dut (
    .clock(clock), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_done(cpu_done),
    .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit), .busy(busy), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         wr;
    logic [9:0] a;
    logic [7:0] d;
  } op_t;

  int checks = 0;
  int errors = 0;

  // Main memory seen by the DUT, and the model's own expectation of it.
  logic [7:0] mem     [1024];
  logic [7:0] ref_mem [1024];
  op_t        mem_log [$];
  op_t        exp_log [$];

  // Behavioural cache model.
  bit         m_valid [4][2];
  bit         m_dirty [4][2];
  logic [7:0] m_tag   [4][2];
  logic [7:0] m_data  [4][2];
  int         m_lru   [4];   // way to evict next when the set is full
  logic [7:0] m_hit, m_miss;

  int ack_delay  = 2;
  int wait_cnt   = 0;
  bit inject_ack = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks after ack_delay cycles, logs every completed access.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clock);
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (inject_ack) begin
        mem_ack    = 1'b1;
        inject_ack = 1'b0;
      end else if (reset_n && (mem_rd || mem_wr)) begin
        chk("mem_rd_wr_exclusive", {31'd0, mem_rd & mem_wr}, 32'd0);
        if (wait_cnt < ack_delay) begin
          wait_cnt++;
        end else begin
          op_t o;
          wait_cnt = 0;
          mem_ack  = 1'b1;
          o.wr = mem_wr;
          o.a  = mem_addr;
          if (mem_wr) begin
            o.d = mem_wdata;
            mem[mem_addr] = mem_wdata;
          end else begin
            mem_rdata = mem[mem_addr];
            o.d = mem_rdata;
          end
          mem_log.push_back(o);
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      m_lru[s] = 0;
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
    m_hit  = 8'd0;
    m_miss = 8'd0;
  endtask

  task automatic model_access(input bit we, input logic [9:0] addr, input logic [7:0] wd,
                              output bit hit, output logic [7:0] rd);
    logic [1:0] s;
    logic [7:0] t;
    int         w;
    int         v;
    op_t        o;
    s = addr[1:0];
    t = addr[9:2];
    w = -1;
    for (int i = 0; i < 2; i++)
      if (m_valid[s][i] && m_tag[s][i] == t) w = i;
    if (w >= 0) begin
      hit = 1'b1;
      m_hit++;
      if (we) begin
        m_data[s][w]  = wd;
        m_dirty[s][w] = 1'b1;
      end
      rd       = m_data[s][w];
      m_lru[s] = 1 - w;
    end else begin
      hit = 1'b0;
      m_miss++;
      v = !m_valid[s][0] ? 0 : (!m_valid[s][1] ? 1 : m_lru[s]);
      if (m_valid[s][v] && m_dirty[s][v]) begin
        o.wr = 1'b1;
        o.a  = {m_tag[s][v], s};
        o.d  = m_data[s][v];
        ref_mem[o.a] = o.d;
        exp_log.push_back(o);
      end
      if (we) begin
        m_data[s][v]  = wd;
        m_dirty[s][v] = 1'b1;
      end else begin
        m_data[s][v]  = ref_mem[addr];
        m_dirty[s][v] = 1'b0;
        o.wr = 1'b0;
        o.a  = addr;
        o.d  = m_data[s][v];
        exp_log.push_back(o);
      end
      m_valid[s][v] = 1'b1;
      m_tag[s][v]   = t;
      m_lru[s]      = 1 - v;
      rd            = m_data[s][v];
    end
  endtask

  // One CPU transaction, entered and left on a negedge.
  task automatic txn(input bit we, input logic [9:0] addr, input logic [7:0] wd, input bit hold);
    bit         exp_hit;
    logic [7:0] exp_rd;
    int         lat;
    bit         got;
    int         n;
    mem_log.delete();
    exp_log.delete();
    model_access(we, addr, wd, exp_hit, exp_rd);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    @(posedge clock);
    if (!hold) begin
      #1;
      cpu_req   = 1'b0;
      cpu_we    = 1'($urandom);
      cpu_addr  = 10'($urandom);
      cpu_wdata = 8'($urandom);
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 200) begin
      @(negedge clock);
      lat++;
      if (cpu_done) got = 1'b1;
    end
    cpu_req = 1'b0;
    chk("cpu_done_seen", {31'd0, cpu_done}, 32'd1);
    chk("cpu_hit", {31'd0, cpu_hit}, {31'd0, exp_hit});
    chk("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, exp_rd});
    chk("hit_cnt", {24'd0, hit_cnt}, {24'd0, m_hit});
    chk("miss_cnt", {24'd0, miss_cnt}, {24'd0, m_miss});
    if (exp_log.size() == 0) chk("latency", lat, 32'd2);
    chk("mem_op_count", mem_log.size(), exp_log.size());
    n = (mem_log.size() < exp_log.size()) ? mem_log.size() : exp_log.size();
    for (int i = 0; i < n; i++) begin
      chk("mem_op_kind", {31'd0, mem_log[i].wr}, {31'd0, exp_log[i].wr});
      chk("mem_op_addr", {22'd0, mem_log[i].a}, {22'd0, exp_log[i].a});
      chk("mem_op_data", {24'd0, mem_log[i].d}, {24'd0, exp_log[i].d});
    end
    $display("txn we=%0d addr=%03h wdata=%02h hit=%0d rdata=%02h lat=%0d memops=%0d",
             we, addr, wd, cpu_hit, cpu_rdata, lat, mem_log.size());
    @(negedge clock);
    chk("done_one_cycle", {31'd0, cpu_done}, 32'd0);
    chk("idle_after_done", {31'd0, busy}, 32'd0);
    chk("rdata_held", {24'd0, cpu_rdata}, {24'd0, exp_rd});
    chk("hit_held", {31'd0, cpu_hit}, {31'd0, exp_hit});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    model_reset();
    repeat (3) @(negedge clock);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, cpu_done}, 32'd0);
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_hit_cnt", {24'd0, hit_cnt}, 32'd0);
    chk("rst_miss_cnt", {24'd0, miss_cnt}, 32'd0);
    chk("rst_rdata", {24'd0, cpu_rdata}, 32'd0);
    chk("rst_hit", {31'd0, cpu_hit}, 32'd0);
    reset_n = 1'b1;

    // Read miss with fill, then hit, write hit, read back.
    mem[10'h041] = 8'h5A; ref_mem[10'h041] = 8'h5A;
    ack_delay = 3;
    txn(1'b0, 10'h041, 8'h00, 1'b0);
    chk("first_fill_data", {24'd0, cpu_rdata}, 32'h5A);
    txn(1'b0, 10'h041, 8'h00, 1'b0);
    chk("first_hit_cnt", {24'd0, hit_cnt}, 32'd1);
    txn(1'b1, 10'h041, 8'hC3, 1'b0);
    txn(1'b0, 10'h041, 8'h00, 1'b0);
    chk("write_hit_readback", {24'd0, cpu_rdata}, 32'hC3);

    // Victim selection: clean victim first, then dirty victim forces write-back.
    ack_delay = 1;
    txn(1'b0, 10'h081, 8'h00, 1'b0);
    txn(1'b0, 10'h041, 8'h00, 1'b0);
    txn(1'b0, 10'h0C1, 8'h00, 1'b0);
    txn(1'b0, 10'h101, 8'h00, 1'b0);

    // Clean write miss installs without memory traffic; req held through DONE.
    do_reset();
    txn(1'b1, 10'h3FE, 8'h77, 1'b1);
    txn(1'b0, 10'h3FE, 8'h00, 1'b1);

    // Reset in the middle of a write-back.
    do_reset();
    txn(1'b1, 10'h041, 8'hC3, 1'b0);
    txn(1'b1, 10'h081, 8'h44, 1'b0);
    ack_delay = 30;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h0C1; cpu_wdata = 8'h00;
    @(posedge clock);
    #1 cpu_req = 1'b0;
    n = 0;
    while (!mem_wr && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("wb_started", {31'd0, mem_wr}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("arst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, cpu_done}, 32'd0);
    chk("arst_hit_cnt", {24'd0, hit_cnt}, 32'd0);
    chk("arst_miss_cnt", {24'd0, miss_cnt}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    ack_delay = 2;
    txn(1'b0, 10'h041, 8'h00, 1'b0);
    chk("post_reset_miss", {31'd0, cpu_hit}, 32'd0);

    // 256 hits wrap the hit counter.
    do_reset();
    txn(1'b0, 10'h3FE, 8'h00, 1'b0);
    for (int i = 0; i < 256; i++) txn(1'b0, 10'h3FE, 8'h00, 1'b0);
    chk("hit_cnt_wrap", {24'd0, hit_cnt}, 32'd0);

    // Stray mem_ack while idle is ignored.
    inject_ack = 1'b1;
    repeat (3) @(negedge clock);
    chk("stray_ack_busy", {31'd0, busy}, 32'd0);
    chk("stray_ack_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("stray_ack_miss_cnt", {24'd0, miss_cnt}, 32'd1);
    txn(1'b0, 10'h3FE, 8'h00, 1'b0);

    // Random traffic over a small tag range so hits, evictions and write-backs all occur.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] t;
      logic [1:0] s;
      t = 8'($urandom_range(0, 5));
      s = 2'($urandom);
      ack_delay = $urandom_range(0, 4);
      txn(1'($urandom), {t, s}, 8'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
